// File: rtl/sine_dac_serializer.sv
// sine_dac_serializer
//   Takes 14-bit signed NCO samples into a one-entry holding buffer and
//   serializes each one to a DAC as a 16-bit frame,
//   {CTRL_BITS, offset-binary sample}, sent MSB first.
//   Frame: SYNC (sync_n low, sclk high, first bit on din), 16 bit periods
//   (sclk low then high, din advances on sclk rise), GAP (all idle).
//   Each phase lasts CLK_DIV enabled cycles.
// Ports
//   clk, reset_n         clock, async active-low reset
//   clken                clock enable; low freezes all state
//   sample_i/_valid_i    sample input, accepted when the buffer is empty
//   ready_o              buffer empty
//   dac_sync_n/sclk/din  registered serial outputs
//   busy_o               frame in progress
//   overrun_o            sticky: sample arrived while buffer full
module sine_dac_serializer #(
  parameter int unsigned CLK_DIV   = 2,
  parameter logic [1:0]  CTRL_BITS = 2'b00
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        clken,
  input  logic [13:0] sample_i,
  input  logic        sample_valid_i,
  output logic        ready_o,
  output logic        dac_sync_n,
  output logic        dac_sclk,
  output logic        dac_din,
  output logic        busy_o,
  output logic        overrun_o
);

  typedef enum logic [1:0] {IDLE, SYNC, SHIFT, GAP} state_t;

  localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

  state_t      state_q, state_d;
  logic        full_q, full_d;
  logic [13:0] buf_q, buf_d;
  logic [14:0] sreg_q, sreg_d;   // bits still to go after the one on din
  logic [7:0]  cnt_q, cnt_d;
  logic [3:0]  bit_q, bit_d;
  logic        high_q, high_d;   // 0: sclk low half of a bit, 1: high half
  logic        sync_n_q, sync_n_d;
  logic        sclk_q, sclk_d;
  logic        din_q, din_d;
  logic        ovr_q, ovr_d;

  logic        load;
  logic        cnt_end;
  logic [15:0] frame;

  assign load    = (state_q == IDLE) && full_q;
  assign cnt_end = (cnt_q == DIV_LAST);
  assign frame   = {CTRL_BITS, buf_q ^ 14'h2000};

  always_comb begin
    state_d  = state_q;
    full_d   = full_q;
    buf_d    = buf_q;
    sreg_d   = sreg_q;
    cnt_d    = cnt_q;
    bit_d    = bit_q;
    high_d   = high_q;
    sync_n_d = sync_n_q;
    sclk_d   = sclk_q;
    din_d    = din_q;
    ovr_d    = ovr_q;

    if (clken) begin
      if (load) full_d = 1'b0;
      // A loading cycle frees the buffer on the same edge, so a sample
      // arriving then is kept even though ready_o reads low.
      if (sample_valid_i) begin
        if (!full_q || load) begin
          buf_d  = sample_i;
          full_d = 1'b1;
        end else begin
          ovr_d = 1'b1;
        end
      end

      case (state_q)
        IDLE: begin
          if (full_q) begin
            state_d  = SYNC;
            sreg_d   = frame[14:0];
            cnt_d    = 8'd0;
            sync_n_d = 1'b0;
            sclk_d   = 1'b1;
            din_d    = frame[15];
          end
        end
        SYNC: begin
          if (cnt_end) begin
            state_d = SHIFT;
            cnt_d   = 8'd0;
            bit_d   = 4'd0;
            high_d  = 1'b0;
            sclk_d  = 1'b0;
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end
        SHIFT: begin
          if (!cnt_end) begin
            cnt_d = cnt_q + 8'd1;
          end else begin
            cnt_d = 8'd0;
            if (!high_q) begin
              // sclk rise: next bit goes out; DAC sampled the old one on the fall
              high_d = 1'b1;
              sclk_d = 1'b1;
              din_d  = sreg_q[14];
              sreg_d = {sreg_q[13:0], 1'b0};
            end else if (bit_q == 4'd15) begin
              state_d  = GAP;
              sync_n_d = 1'b1;
              din_d    = 1'b0;
            end else begin
              bit_d  = bit_q + 4'd1;
              high_d = 1'b0;
              sclk_d = 1'b0;
            end
          end
        end
        GAP: begin
          if (cnt_end) begin
            state_d = IDLE;
            cnt_d   = 8'd0;
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      full_q   <= 1'b0;
      buf_q    <= '0;
      sreg_q   <= '0;
      cnt_q    <= '0;
      bit_q    <= '0;
      high_q   <= 1'b0;
      sync_n_q <= 1'b1;
      sclk_q   <= 1'b1;
      din_q    <= 1'b0;
      ovr_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      full_q   <= full_d;
      buf_q    <= buf_d;
      sreg_q   <= sreg_d;
      cnt_q    <= cnt_d;
      bit_q    <= bit_d;
      high_q   <= high_d;
      sync_n_q <= sync_n_d;
      sclk_q   <= sclk_d;
      din_q    <= din_d;
      ovr_q    <= ovr_d;
    end
  end

  assign ready_o    = ~full_q;
  assign busy_o     = (state_q != IDLE);
  assign dac_sync_n = sync_n_q;
  assign dac_sclk   = sclk_q;
  assign dac_din    = din_q;
  assign overrun_o  = ovr_q;

endmodule

// File: tb/tb_sine_dac_serializer.sv
// Bench for sine_dac_serializer: two instances (CTRL_BITS 00 and 11) share
// the stimulus; a negedge monitor decodes frames on DAC sclk falls.
module tb_sine_dac_serializer;
  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        clken = 1'b1;
  logic [13:0] sample = '0;
  logic        valid = 1'b0;

  logic rdy_a, sync_a, sclk_a, din_a, busy_a, ovr_a;
  logic rdy_b, sync_b, sclk_b, din_b, busy_b, ovr_b;

  always #5 clk = ~clk;

  sine_dac_serializer #(.CLK_DIV(2), .CTRL_BITS(2'b00)) dut_a (
    .clk(clk), .reset_n(reset_n), .clken(clken), .sample_i(sample),
    .sample_valid_i(valid), .ready_o(rdy_a), .dac_sync_n(sync_a),
    .dac_sclk(sclk_a), .dac_din(din_a), .busy_o(busy_a), .overrun_o(ovr_a));

  sine_dac_serializer #(.CLK_DIV(2), .CTRL_BITS(2'b11)) dut_b (
    .clk(clk), .reset_n(reset_n), .clken(clken), .sample_i(sample),
    .sample_valid_i(valid), .ready_o(rdy_b), .dac_sync_n(sync_b),
    .dac_sclk(sclk_b), .dac_din(din_b), .busy_o(busy_b), .overrun_o(ovr_b));

  int total = 0;
  int bad = 0;

  // monitor state (written only by the monitor)
  logic        prev_sclk = 1'b1;
  logic        prev_sync = 1'b1;
  logic [15:0] wa = '0, wb = '0;
  int          nb = 0;
  logic [15:0] fr_a [0:255];
  logic [15:0] fr_b [0:255];
  int          nfa = 0;
  int          fall_cnt = 0, sync_cnt = 0, busy_cnt = 0, rdy_low_cnt = 0, glitch_cnt = 0;

  always @(negedge clk) begin
    if (!reset_n) begin
      nb <= 0;
    end else begin
      if (busy_a) busy_cnt <= busy_cnt + 1;
      if (!sync_a) sync_cnt <= sync_cnt + 1;
      if (!rdy_a) rdy_low_cnt <= rdy_low_cnt + 1;
      if (!sclk_a && !prev_sclk && (sync_a != prev_sync)) glitch_cnt <= glitch_cnt + 1;
      if (sync_a) begin
        nb <= 0;
      end else if (prev_sclk && !sclk_a) begin
        fall_cnt <= fall_cnt + 1;
        if (nb == 15) begin
          fr_a[nfa[7:0]] <= {wa[14:0], din_a};
          fr_b[nfa[7:0]] <= {wb[14:0], din_b};
          nfa <= nfa + 1;
          nb  <= 0;
        end else begin
          wa <= {wa[14:0], din_a};
          wb <= {wb[14:0], din_b};
          nb <= nb + 1;
        end
      end
    end
    prev_sclk <= sclk_a;
    prev_sync <= sync_a;
  end

  task automatic send(input logic [13:0] s);
    @(negedge clk);
    sample = s;
    valid  = 1'b1;
    @(negedge clk);
    valid  = 1'b0;
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic wait_frames(input int target, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (nfa >= target && !busy_a) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    total++; if (rdy_a !== 1'b1)  begin bad++; $display("FAIL reset_ready got %b want 1", rdy_a); end
    total++; if (sync_a !== 1'b1) begin bad++; $display("FAIL reset_sync_n got %b want 1", sync_a); end
    total++; if (sclk_a !== 1'b1) begin bad++; $display("FAIL reset_sclk got %b want 1", sclk_a); end
    total++; if (din_a !== 1'b0)  begin bad++; $display("FAIL reset_din got %b want 0", din_a); end
    total++; if (busy_a !== 1'b0) begin bad++; $display("FAIL reset_busy got %b want 0", busy_a); end
    total++; if (ovr_a !== 1'b0)  begin bad++; $display("FAIL reset_overrun got %b want 0", ovr_a); end
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_frame(input logic [13:0] s, input logic [15:0] ea, input logic [15:0] eb);
    int f0, b0, s0, c0;
    bit ok;
    f0 = nfa; b0 = busy_cnt; s0 = sync_cnt; c0 = fall_cnt;
    send(s);
    wait_frames(f0 + 1, ok);
    total++; if (!ok) begin bad++; $display("FAIL frame_timeout got %0d frames want %0d", nfa, f0 + 1); end
    total++; if (fr_a[f0[7:0]] !== ea) begin bad++; $display("FAIL frame_a got %h want %h", fr_a[f0[7:0]], ea); end
    total++; if (fr_b[f0[7:0]] !== eb) begin bad++; $display("FAIL frame_b got %h want %h", fr_b[f0[7:0]], eb); end
    total++; if (busy_cnt - b0 != 68) begin bad++; $display("FAIL busy_cycles got %0d want 68", busy_cnt - b0); end
    total++; if (sync_cnt - s0 != 66) begin bad++; $display("FAIL sync_low_cycles got %0d want 66", sync_cnt - s0); end
    total++; if (fall_cnt - c0 != 16) begin bad++; $display("FAIL sclk_falls got %0d want 16", fall_cnt - c0); end
  endtask

  task automatic test_overrun();
    int f0;
    bit ok;
    f0 = nfa;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      sample = 14'h0100 + 14'(i);
      valid  = 1'b1;
    end
    @(negedge clk);
    valid = 1'b0;
    wait_frames(f0 + 2, ok);
    total++; if (!ok) begin bad++; $display("FAIL overrun_timeout got %0d frames want %0d", nfa, f0 + 2); end
    total++; if (fr_a[f0[7:0]] !== 16'h2100) begin bad++; $display("FAIL overrun_first got %h want 2100", fr_a[f0[7:0]]); end
    total++; if (fr_a[8'(f0 + 1)] !== 16'h2101) begin bad++; $display("FAIL overrun_second got %h want 2101", fr_a[8'(f0 + 1)]); end
    total++; if (ovr_a !== 1'b1) begin bad++; $display("FAIL overrun_set got %b want 1", ovr_a); end
    repeat (30) @(negedge clk);
    total++; if (nfa != f0 + 2) begin bad++; $display("FAIL overrun_extra_frames got %0d want %0d", nfa, f0 + 2); end
    total++; if (ovr_a !== 1'b1) begin bad++; $display("FAIL overrun_sticky got %b want 1", ovr_a); end
    pulse_reset();
    total++; if (ovr_a !== 1'b0) begin bad++; $display("FAIL overrun_cleared got %b want 0", ovr_a); end
  endtask

  task automatic test_stream();
    int f0, r0, errs;
    bit ok;
    logic [13:0] s;
    logic [15:0] e;
    f0 = nfa; r0 = rdy_low_cnt; errs = 0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      sample = 14'(k * 97 + 5);
      valid  = 1'b1;
      @(negedge clk);
      valid  = 1'b0;
      repeat (67) @(negedge clk);
    end
    wait_frames(f0 + 100, ok);
    for (int k = 0; k < 100; k++) begin
      s = 14'(k * 97 + 5);
      e = {2'b00, s ^ 14'h2000};
      if (fr_a[8'(f0 + k)] !== e) errs++;
    end
    total++; if (!ok) begin bad++; $display("FAIL stream_timeout got %0d frames want %0d", nfa - f0, 100); end
    total++; if (errs != 0) begin bad++; $display("FAIL stream_order got %0d bad frames want 0", errs); end
    total++; if (ovr_a !== 1'b0) begin bad++; $display("FAIL stream_overrun got %b want 0", ovr_a); end
    total++; if (rdy_low_cnt - r0 != 100) begin bad++; $display("FAIL stream_ready_low got %0d want 100", rdy_low_cnt - r0); end
  endtask

  task automatic test_reset_mid();
    int f0, c0;
    bit ok;
    f0 = nfa; c0 = fall_cnt; ok = 1'b0;
    send(14'h0555);
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      if (fall_cnt - c0 >= 7) begin ok = 1'b1; break; end
    end
    total++; if (!ok) begin bad++; $display("FAIL midreset_reach got %0d falls want 7", fall_cnt - c0); end
    #2 reset_n = 1'b0;
    #1;
    total++; if ({sync_a, sclk_a, din_a, rdy_a, busy_a} !== 5'b11010)
      begin bad++; $display("FAIL midreset_outputs got %b want 11010", {sync_a, sclk_a, din_a, rdy_a, busy_a}); end
    @(negedge clk);
    reset_n = 1'b1;
    repeat (3) @(negedge clk);
    total++; if (nfa != f0) begin bad++; $display("FAIL midreset_partial got %0d frames want %0d", nfa, f0); end
    send(14'h0AAA);
    wait_frames(f0 + 1, ok);
    total++; if (!ok || fr_a[f0[7:0]] !== 16'h2AAA)
      begin bad++; $display("FAIL midreset_next got %h want 2aaa", fr_a[f0[7:0]]); end
  endtask

  task automatic test_clken();
    int f0, b0, c0, changes;
    bit ok;
    logic [2:0] snap;
    f0 = nfa; b0 = busy_cnt; c0 = fall_cnt; changes = 0; ok = 1'b0;
    send(14'h1234);
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      if (fall_cnt - c0 >= 5) begin ok = 1'b1; break; end
    end
    snap  = {sync_a, sclk_a, din_a};
    clken = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if ({sync_a, sclk_a, din_a} != snap) changes++;
    end
    clken = 1'b1;
    wait_frames(f0 + 1, ok);
    total++; if (!ok) begin bad++; $display("FAIL clken_timeout got %0d frames want %0d", nfa, f0 + 1); end
    total++; if (changes != 0) begin bad++; $display("FAIL clken_frozen got %0d changes want 0", changes); end
    total++; if (fr_a[f0[7:0]] !== 16'h3234) begin bad++; $display("FAIL clken_frame_a got %h want 3234", fr_a[f0[7:0]]); end
    total++; if (fr_b[f0[7:0]] !== 16'hF234) begin bad++; $display("FAIL clken_frame_b got %h want f234", fr_b[f0[7:0]]); end
    total++; if (busy_cnt - b0 != 78) begin bad++; $display("FAIL clken_busy got %0d want 78", busy_cnt - b0); end
    total++; if (fall_cnt - c0 != 16) begin bad++; $display("FAIL clken_falls got %0d want 16", fall_cnt - c0); end
  endtask

  initial begin
    test_reset();
    test_frame(14'h0000, 16'h2000, 16'hE000);
    test_frame(14'h1FFF, 16'h3FFF, 16'hFFFF);
    test_frame(14'h2000, 16'h0000, 16'hC000);
    test_frame(14'h0A5A, 16'h2A5A, 16'hEA5A);
    test_overrun();
    test_stream();
    test_reset_mid();
    test_clken();
    total++; if (glitch_cnt != 0) begin bad++; $display("FAIL sync_while_sclk_low got %0d want 0", glitch_cnt); end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sine_dac_serializer.md
SINE_DAC_SERIALIZER -- requirements
Module: sine_dac_serializer

Interface
REQ-001 Parameter CLK_DIV, default 2, meaning clk cycles per dac_sclk half-period; legal range 1..255.
REQ-002 Parameter CTRL_BITS, default 2'b00, meaning 2 control bits sent ahead of each sample.
REQ-003 clk  input  1  sole clock, rising-edge; all logic in this single domain.
REQ-004 reset_n  input  1  reset, asynchronous assert, active-low.
REQ-005 clken  input  1  clock enable; when low, all state frozen and no sample accepted.
REQ-006 sample_i  input  14  signed two's-complement sample, the NCO fsin_o/fcos_o format.
REQ-007 sample_valid_i  input  1  sample_i valid this cycle; driven from the NCO out_valid.
REQ-008 ready_o  output  1  holding buffer empty; sample accepted when clken & sample_valid_i & ready_o.
REQ-009 dac_sync_n  output  1  DAC frame select, active-low.
REQ-010 dac_sclk  output  1  DAC serial clock; idle high.
REQ-011 dac_din  output  1  DAC serial data, MSB first.
REQ-012 busy_o  output  1  high whenever FSM is not IDLE.
REQ-013 overrun_o  output  1  sticky; sample presented while buffer full.

Function
REQ-014 Holding buffer: one 14-bit entry plus full flag; ready_o = ~full, combinational from the flag only.
REQ-015 Accept: buffer stores sample_i and sets full on the same edge; sample_valid_i while full -> sample dropped, buffer unchanged, overrun_o set.
REQ-016 Frame word = {CTRL_BITS, sample_i ^ 14'h2000} (offset binary), 16 bits, MSB first.
REQ-017 FSM states IDLE, SYNC, SHIFT, GAP; all transitions and counters advance only when clken=1.
REQ-018 IDLE: sync_n=1, sclk=1; if full -> load shift register from buffer, clear full, go SYNC (same edge).
REQ-019 Load and accept in the same cycle are allowed: buffer takes the new sample, shift register takes the old one.
REQ-020 SYNC: sync_n=0, sclk=1, din=frame bit 15, held CLK_DIV cycles, then SHIFT.
REQ-021 SHIFT: per bit, sclk low CLK_DIV cycles, then high CLK_DIV cycles; din changes only on sclk low->high; the DAC samples on high->low.
REQ-022 After the 16th bit's high phase -> GAP: sync_n=1, sclk=1, din=0, CLK_DIV cycles, then IDLE.
REQ-023 Frame period from load to IDLE = 34*CLK_DIV enabled cycles (68 at default).
REQ-024 Sustained input throughput: one sample per 34*CLK_DIV+1 cycles without overrun.
REQ-025 All serial outputs registered, glitch-free; sync_n never toggles while sclk is low.
REQ-026 clken low mid-frame: outputs hold current levels, resume exactly where frozen.

Reset
REQ-027 reset_n=0 asynchronously forces: FSM IDLE, full=0, shift register 0, bit/phase counters 0.
REQ-028 Reset values: ready_o=1, dac_sync_n=1, dac_sclk=1, dac_din=0, busy_o=0, overrun_o=0.
REQ-029 Reset mid-frame aborts the frame; the partial frame is not resumed after release.
REQ-030 Outputs follow reset release; first accept is possible on the first enabled edge after release.

Verification
REQ-031 sample_i=14'h0000, CLK_DIV=2 -> frame 16'h2000 on din; sync_n low 66 cycles; 16 sclk falling edges; busy_o high 68 cycles.
REQ-032 sample_i=14'h1FFF (+8191) -> 16'h3FFF; 14'h2000 (-8192) -> 16'h0000; CTRL_BITS=2'b11 with 14'h0000 -> 16'hE000.
REQ-033 NCO-driven stream with valid every cycle -> first sample framed, second buffered, rest dropped; overrun_o=1 and remains 1 until reset.
REQ-034 Valid every 69 cycles for 100 samples -> all 100 frames sent in order, overrun_o stays 0, ready_o low only from accept to load.
REQ-035 reset_n low at bit 7 of a frame -> within the same cycle sync_n=1, sclk=1, din=0, ready_o=1; next sample produces a complete frame.
REQ-036 clken low for 10 cycles during SHIFT -> no edge on sclk/sync_n/din during the gap; frame completes 10 cycles later with identical bit content.
